boot_copy_ctrl: RTL and testbench
=================================

BOOT_COPY_CTRL -- requirements
Module: boot_copy_ctrl

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
- ROM_FIRST, 8'hDF, first populated boot ROM word address
- ROM_LAST, 8'hFF, last boot ROM word address copied (inclusive)
- RAM_BASE, 16'hFFDF, RAM word address receiving ROM word ROM_FIRST
- HOLD_CYCLES, 4, cycles cpu_rst stays high after copy/verify completes (1..255)
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
- clk, in, 1, single system clock; all state changes on rising edge
- reset_n, in, 1, synchronous active-low reset, sampled on clk rising edge
- rom_addr, out, 8, word address to combinational boot ROM
- rom_data, in, 16, ROM word for rom_addr, valid same cycle
- ram_addr, out, 16, RAM word address
- ram_wdata, out, 16, RAM write data
- ram_we, out, 1, RAM write request
- ram_ready, in, 1, RAM accepts request this cycle
- reboot, in, 1, single-cycle request to re-run boot copy
- cpu_rst, out, 1, active-high hold to the CPU core
- done, out, 1, copy complete and CPU released
- ram_re, out, 1, RAM read request (BOOT_VERIFY_EN only)
- ram_rdata, in, 16, RAM read data (BOOT_VERIFY_EN only)
- ram_rvalid, in, 1, ram_rdata valid (BOOT_VERIFY_EN only)
- err, out, 1, verify mismatch, sticky (BOOT_VERIFY_EN only)

Function
REQ-003 SHALL implement states COPY, VERIFY (BOOT_VERIFY_EN only), HOLD, RUN, FAIL (BOOT_VERIFY_EN only).
REQ-004 In COPY, ram_we SHALL be 1, ram_wdata SHALL equal rom_data, and ram_addr SHALL equal RAM_BASE + (rom_addr - ROM_FIRST), modulo 2^16.
REQ-005 A write SHALL complete only on a cycle with ram_we=1 and ram_ready=1; rom_addr SHALL advance by one on the next edge; with ram_ready=0 all outputs SHALL hold.
REQ-006 The word count SHALL be ROM_LAST-ROM_FIRST+1 (33 by default). The rom_addr counter SHALL NOT wrap: completion of the ROM_LAST write leaves COPY with no write to address 8'h00.
REQ-007 With ram_ready tied to 1, COPY SHALL last exactly 33 cycles (default parameters).
REQ-008 On leaving COPY (or VERIFY), SHALL enter HOLD, keep cpu_rst=1 for exactly HOLD_CYCLES cycles, then enter RUN.
REQ-009 In RUN, cpu_rst SHALL be 0 and done SHALL be 1; ram_we and ram_re SHALL be 0.
REQ-010 reboot=1 in RUN SHALL, on the next edge, set cpu_rst=1 and done=0, reset rom_addr to ROM_FIRST, and enter COPY.
REQ-011 reboot SHALL be ignored in COPY, VERIFY, HOLD and FAIL.
REQ-012 cpu_rst SHALL be 1 in every state except RUN.

Reset
REQ-013 While reset_n=0 at a clk edge: state=COPY, rom_addr=ROM_FIRST, ram_addr=RAM_BASE, cpu_rst=1, done=0, ram_re=0, err=0, hold counter=0. ram_we SHALL go to 1 in the first cycle after reset_n is sampled high.
REQ-014 reset_n low mid-copy SHALL abandon the transfer; the copy SHALL restart from ROM_FIRST, with no partial state retained.

Configuration
REQ-015 Macro BOOT_VERIFY_EN: when defined, after COPY SHALL enter VERIFY and re-read each RAM word ROM_FIRST..ROM_LAST. The address advances on ram_re and ram_ready. Each ram_rvalid beat is compared in order against the ROM word for the same address. At most one read SHALL be outstanding.
REQ-016 With BOOT_VERIFY_EN, all matches SHALL enter HOLD. The first mismatch SHALL enter FAIL with err=1 and cpu_rst=1 until reset_n. reboot SHALL NOT clear FAIL.
REQ-017 Without BOOT_VERIFY_EN: VERIFY and FAIL are absent, ram_re and err SHALL be driven 0, ram_rdata and ram_rvalid are ignored, and COPY goes directly to HOLD.

Verification
REQ-018 Reset release, ram_ready=1, default parameters -> 33 writes, RAM[FFDF]=00A2 ... RAM[FFFF]=FFFF; cpu_rst falls exactly 4 cycles after the last write; done=1.
REQ-019 ram_ready low for 3 cycles at word 8'hE4 -> ram_addr=FFE4 and ram_wdata=A5C3 held stable; no duplicate or skipped write.
REQ-020 reboot pulse in RUN -> cpu_rst=1 and done=0 next cycle, full 33-word copy repeats; reboot pulses during COPY have no effect.
REQ-021 reset_n low after 10 writes -> outputs at reset values; the next copy starts at FFDF; RAM ends fully and correctly written.
REQ-022 BOOT_VERIFY_EN, RAM model corrupts FFF5 to 0048 -> err=1, state FAIL, cpu_rst stays 1, done=0; a reboot pulse does not change this.
REQ-023 Build without BOOT_VERIFY_EN -> ram_re=0 and err=0 throughout; HOLD is entered on the cycle after the last write.

Source files
------------

// File: rtl/boot_copy_ctrl.sv
// Boot copy controller: copies the boot ROM into RAM, holds the CPU in reset, then releases it.
// Optional read-back check of every copied word is compiled in with `define BOOT_VERIFY_EN.
module boot_copy_ctrl #(
  parameter logic [7:0]  ROM_FIRST   = 8'hDF,
  parameter logic [7:0]  ROM_LAST    = 8'hFF,
  parameter logic [15:0] RAM_BASE    = 16'hFFDF,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic        ram_ready,
  input  logic        reboot,
  output logic        cpu_rst,
  output logic        done,
  output logic        ram_re,
  input  logic [15:0] ram_rdata,
  input  logic        ram_rvalid,
  output logic        err
);

  // Last value of the hold counter before the CPU is released.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

`ifdef BOOT_VERIFY_EN
  typedef enum logic [2:0] {
    S_COPY   = 3'd0,
    S_HOLD   = 3'd1,
    S_RUN    = 3'd2,
    S_VERIFY = 3'd3,
    S_FAIL   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_COPY = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;
`endif

  state_t     state;
  logic [7:0] hold_cnt;

`ifdef BOOT_VERIFY_EN
  // A read has been accepted and its data beat is still awaited.
  logic        pend;
  // The outstanding read is for the ROM_LAST word.
  logic        last_rd;
  // ROM word captured when the read was accepted.
  logic [15:0] exp_data;
`else
  assign ram_re = 1'b0;
  assign err    = 1'b0;

  logic unused_rd;
  assign unused_rd = ^{ram_rdata, ram_rvalid};
`endif

  // Write data comes straight from the combinational ROM for the current address.
  assign ram_wdata = rom_data;

  // Controller FSM: copy, optional verify, hold, run; all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_COPY;
      rom_addr <= ROM_FIRST;
      ram_addr <= RAM_BASE;
      ram_we   <= 1'b0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      hold_cnt <= 8'd0;
`ifdef BOOT_VERIFY_EN
      ram_re   <= 1'b0;
      err      <= 1'b0;
      pend     <= 1'b0;
      last_rd  <= 1'b0;
      exp_data <= 16'd0;
`endif
    end else begin
      unique case (state)
        S_COPY: begin
          if (!ram_we) begin
            ram_we <= 1'b1;
          end else if (ram_ready) begin
            if (rom_addr == ROM_LAST) begin
              ram_we <= 1'b0;
`ifdef BOOT_VERIFY_EN
              state    <= S_VERIFY;
              rom_addr <= ROM_FIRST;
              ram_addr <= RAM_BASE;
              ram_re   <= 1'b1;
`else
              state    <= S_HOLD;
              hold_cnt <= 8'd0;
`endif
            end else begin
              rom_addr <= rom_addr + 8'd1;
              ram_addr <= ram_addr + 16'd1;
            end
          end
        end
`ifdef BOOT_VERIFY_EN
        S_VERIFY: begin
          if (ram_re) begin
            if (ram_ready) begin
              ram_re   <= 1'b0;
              pend     <= 1'b1;
              exp_data <= rom_data;
              last_rd  <= (rom_addr == ROM_LAST);
              if (rom_addr != ROM_LAST) begin
                rom_addr <= rom_addr + 8'd1;
                ram_addr <= ram_addr + 16'd1;
              end
            end
          end else if (pend && ram_rvalid) begin
            pend <= 1'b0;
            if (ram_rdata != exp_data) begin
              state <= S_FAIL;
              err   <= 1'b1;
            end else if (last_rd) begin
              state    <= S_HOLD;
              hold_cnt <= 8'd0;
            end else begin
              ram_re <= 1'b1;
            end
          end
        end
        S_FAIL: begin
          cpu_rst <= 1'b1;
          done    <= 1'b0;
        end
`endif
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= S_RUN;
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (reboot) begin
            state    <= S_COPY;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            rom_addr <= ROM_FIRST;
            ram_addr <= RAM_BASE;
            ram_we   <= 1'b1;
          end
        end
        default: begin
          state <= S_COPY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Self-checking bench for boot_copy_ctrl: ROM/RAM models, write scoreboard, timing checks.
// Verify-path sequence is included when BOOT_VERIFY_EN is defined.
module tb_boot_copy_ctrl;

  localparam int HOLD = 4;
  localparam int NW   = 33;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_ready;
  logic        reboot;
  logic        cpu_rst;
  logic        done;
  logic        ram_re;
  logic [15:0] ram_rdata = 16'h0;
  logic        ram_rvalid = 1'b0;
  logic        err;

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  assign rom_data = rom[rom_addr];

  boot_copy_ctrl #(
    .ROM_FIRST(8'hDF),
    .ROM_LAST(8'hFF),
    .RAM_BASE(16'hFFDF),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_ready(ram_ready),
    .reboot(reboot),
    .cpu_rst(cpu_rst),
    .done(done),
    .ram_re(ram_re),
    .ram_rdata(ram_rdata),
    .ram_rvalid(ram_rvalid),
    .err(err)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          c;
  } wr_t;

  typedef struct {
    logic [7:0]  ra;
    logic [15:0] rd;
    logic [15:0] ea;
  } vec_t;

  wr_t         wlog[$];
  logic [15:0] ram_mem [int];
  vec_t        vt [6];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  int          last_evt = 0;
  int          stall_cyc = 0;
  int          stall_bad = 0;
  bit          prev_cpu = 1'b1;
  bit          stall_prev = 1'b0;
  bit          side_bad = 1'b0;
  bit          rd_go = 1'b0;
  bit          corrupt = 1'b0;
  logic [15:0] prev_a = 16'h0;
  logic [15:0] prev_d = 16'h0;
  logic [15:0] rd_addr = 16'h0;

  // RAM model and observers, sampled mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_we === 1'b1 && ram_ready) begin
      ram_mem[int'(ram_addr)] = ram_wdata;
      wlog.push_back('{ram_addr, ram_wdata, cyc});
      last_evt = cyc;
    end
    if (ram_rvalid) last_evt = cyc;
    if (prev_cpu && cpu_rst === 1'b0) fall_cyc = cyc;
    prev_cpu = (cpu_rst !== 1'b0);
    if (stall_prev) begin
      stall_cyc = stall_cyc + 1;
      if (ram_we !== 1'b1 || ram_addr !== prev_a || ram_wdata !== prev_d)
        stall_bad = stall_bad + 1;
    end
    stall_prev = (ram_we === 1'b1) && !ram_ready && reset_n;
    prev_a = ram_addr;
    prev_d = ram_wdata;
    if (cyc > 2 && (ram_re !== 1'b0 || err !== 1'b0)) side_bad = 1'b1;
    rd_go = (ram_re === 1'b1) && ram_ready && reset_n;
    rd_addr = ram_addr;
  end

  // RAM read response one cycle after an accepted read
  always @(posedge clk) begin
    #1;
    ram_rvalid = rd_go;
    if (corrupt && rd_addr == 16'hFFF5)
      ram_rdata = 16'h0048;
    else
      ram_rdata = ram_mem.exists(int'(rd_addr)) ? ram_mem[int'(rd_addr)] : 16'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick;
      ram_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      reboot = rnd && !done && ($urandom_range(0, 7) == 0);
      smp;
      if (done) ok = 1'b1;
    end
    reboot = 1'b0;
    ram_ready = 1'b1;
    chk("done_reached", ok, 1);
  endtask

  // Expected: word i of a copy goes to RAM_BASE+i with the ROM word at ROM_FIRST+i
  task automatic check_copy(input int base, input string tag);
    int n;
    n = wlog.size() - base;
    chk({tag, "_count"}, n, NW);
    for (int i = 0; i < NW; i++) begin
      if (base + i < wlog.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), wlog[base+i].a, 16'(32'hFFDF + i));
        chk($sformatf("%s_data%0d", tag, i), wlog[base+i].d, rom[8'(32'hDF + i)]);
      end
    end
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_hold_len"}, fall_cyc - last_evt, HOLD + 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cpu_rst"}, cpu_rst, 0);
    chk({tag, "_we_run"}, ram_we, 0);
    chk({tag, "_re_run"}, ram_re, 0);
  endtask

  task automatic pulse_reboot;
    tick;
    reboot = 1'b1;
    tick;
    reboot = 1'b0;
  endtask

  initial begin
    int  base;
    int  base2;
    int  lc;
    int  fc;
    int  bad;
    int  sb;
    bit  hit;
    reset_n   = 1'b0;
    ram_ready = 1'b1;
    reboot    = 1'b0;

    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    vt[0] = '{8'hDF, 16'h00A2, 16'hFFDF};
    vt[1] = '{8'hE4, 16'hA5C3, 16'hFFE4};
    vt[2] = '{8'hF5, 16'h1234, 16'hFFF5};
    vt[3] = '{8'hFF, 16'hFFFF, 16'hFFFF};
    vt[4] = '{8'hE0, 16'h5A5A, 16'hFFE0};
    vt[5] = '{8'hFE, 16'h8001, 16'hFFFE};
    for (int i = 0; i < 6; i++) rom[vt[i].ra] = vt[i].rd;
    rom[8'h00] = 16'hBEEF;

    // reset values
    repeat (3) tick;
    smp;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_rom_addr", rom_addr, 8'hDF);
    chk("rst_ram_addr", ram_addr, 16'hFFDF);
    chk("rst_re", ram_re, 0);
    chk("rst_err", err, 0);

    // first write appears in the cycle after reset_n is sampled high
    base = wlog.size();
    tick;
    reset_n = 1'b1;
    smp;
    chk("we_pre_edge", ram_we, 0);
    tick;
    smp;
    chk("we_first", ram_we, 1);
    chk("first_rom_addr", rom_addr, 8'hDF);
    chk("first_ram_addr", ram_addr, 16'hFFDF);
    chk("first_wdata", ram_wdata, 16'h00A2);
    wait_done(1'b0, 200);
    check_copy(base, "boot");
    lc = (wlog.size() > base) ? wlog[wlog.size()-1].c : 0;
    fc = (wlog.size() > base) ? wlog[base].c : 0;
    chk("boot_copy_len", lc - fc, NW - 1);
    check_hold("boot");
    chk("no_wrap_write", ram_mem.exists(0), 0);
    chk("no_write_below", ram_mem.exists(32'hFFDE), 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec_%h", vt[i].ea),
          ram_mem.exists(int'(vt[i].ea)) ? ram_mem[int'(vt[i].ea)] : 16'h0,
          vt[i].rd);
    end
    repeat (5) tick;
    smp;
    chk("run_stable_done", done, 1);

    // reboot, ignored reboot pulses in COPY, 3-cycle stall at E4
    base = wlog.size();
    sb = stall_cyc;
    pulse_reboot;
    smp;
    chk("reboot_cpu_rst", cpu_rst, 1);
    chk("reboot_done", done, 0);
    chk("reboot_rom_addr", rom_addr, 8'hDF);
    chk("reboot_ram_addr", ram_addr, 16'hFFDF);
    chk("reboot_we", ram_we, 1);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      smp;
      if (rom_addr == 8'hE3) hit = 1'b1;
      else begin
        tick;
        reboot = (i == 0) || (i == 2);
      end
    end
    chk("reach_e3", hit, 1);
    tick;
    reboot = 1'b0;
    ram_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp;
      chk($sformatf("stall%0d_addr", k), ram_addr, 16'hFFE4);
      chk($sformatf("stall%0d_data", k), ram_wdata, 16'hA5C3);
      chk($sformatf("stall%0d_we", k), ram_we, 1);
      tick;
    end
    ram_ready = 1'b1;
    wait_done(1'b0, 200);
    check_copy(base, "stall");
    chk("stall_cycles", stall_cyc - sb, 3);
    chk("stall_stable", stall_bad, 0);
    check_hold("stall");

    // new ROM image, random ready, reset after 10 writes, full restart
    for (int i = 8'hDF; i <= 8'hFF; i++) rom[i] = 16'($urandom);
    base = wlog.size();
    pulse_reboot;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick;
      ram_ready = ($urandom_range(0, 3) != 0);
      smp;
      if (wlog.size() - base >= 10) hit = 1'b1;
    end
    chk("pre_reset_writes", wlog.size() - base, 10);
    tick;
    reset_n = 1'b0;
    ram_ready = 1'b1;
    tick;
    smp;
    chk("mid_rst_cpu_rst", cpu_rst, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_rom_addr", rom_addr, 8'hDF);
    chk("mid_rst_ram_addr", ram_addr, 16'hFFDF);
    base2 = wlog.size();
    tick;
    reset_n = 1'b1;
    wait_done(1'b1, 800);
    check_copy(base2, "restart");
    check_hold("restart");
    bad = 0;
    for (int i = 0; i < NW; i++) begin
      if (!ram_mem.exists(32'hFFDF + i) || ram_mem[32'hFFDF + i] !== rom[8'(32'hDF + i)])
        bad = bad + 1;
    end
    chk("ram_final_image", bad, 0);

`ifndef BOOT_VERIFY_EN
    chk("no_verify_outputs", side_bad, 0);
`endif

`ifdef BOOT_VERIFY_EN
    // corrupted read-back of FFF5 must latch FAIL
    corrupt = 1'b1;
    pulse_reboot;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick;
      smp;
      if (err) hit = 1'b1;
    end
    chk("vfy_err", err, 1);
    chk("vfy_cpu_rst", cpu_rst, 1);
    chk("vfy_done", done, 0);
    pulse_reboot;
    repeat (3) tick;
    smp;
    chk("vfy_err_sticky", err, 1);
    chk("vfy_cpu_rst_sticky", cpu_rst, 1);
    chk("vfy_done_sticky", done, 0);
    chk("vfy_we_idle", ram_we, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
